// File: rtl/shift_add_mul_pkg.sv
// Shared types for the shift-and-add multiplier: FSM state encoding and counter width helper.
package shift_add_mul_pkg;

   typedef enum logic [1:0] {
      ST_IDLE = 2'b00,
      ST_RUN  = 2'b01,
      ST_DONE = 2'b10
   } mul_state_t;

   // Iteration counter must hold WIDTH-1; never narrower than one bit.
   function automatic int unsigned CNT_W(input int unsigned width);
      return (width <= 2) ? 1 : $clog2(width);
   endfunction

endpackage

// File: rtl/add_nbit.sv
// Combinational WIDTH-bit carry-lookahead adder, carry-in 0, WIDTH+1-bit sum.
module add_nbit #(
   parameter int unsigned WIDTH = 8
) (
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   output logic [WIDTH:0]   sum
);

   logic [WIDTH-1:0] g;
   logic [WIDTH-1:0] p;
   logic [WIDTH:0]   c;

   assign g = a & b;
   assign p = a ^ b;

   // Each carry is the flat OR of generate terms propagated through higher bits.
   always_comb begin
      logic carry;
      logic term;
      c = '0;
      for (int i = 0; i < int'(WIDTH); i++) begin
         carry = 1'b0;
         for (int j = 0; j <= i; j++) begin
            term = g[j];
            for (int k = j + 1; k <= i; k++) begin
               term = term & p[k];
            end
            carry = carry | term;
         end
         c[i+1] = carry;
      end
   end

   assign sum = {c[WIDTH], p ^ c[WIDTH-1:0]};

endmodule

// File: rtl/shift_add_mul.sv
// Sequential unsigned WIDTH x WIDTH shift-and-add multiplier, one add per clock.
// Optional MUL_ZERO_BYPASS_EN: zero operands finish in one cycle without iterating.
module shift_add_mul
   import shift_add_mul_pkg::*;
#(
   parameter int unsigned WIDTH = 8
) (
   input  logic               clk,
   input  logic               rst_n,
   input  logic               start,
   input  logic [WIDTH-1:0]   A,
   input  logic [WIDTH-1:0]   B,
   output logic               busy,
   output logic               done,
   output logic [2*WIDTH-1:0] P
);

   localparam int unsigned CW = CNT_W(WIDTH);

   mul_state_t state_q, state_d;

   logic [WIDTH-1:0]   m_q;
   logic [WIDTH-1:0]   acc_q;
   logic [WIDTH-1:0]   q_q;
   logic [CW-1:0]      cnt_q;
   logic [2*WIDTH-1:0] p_q;

   logic             accept;
   logic             zero_op;
   logic             last;
   logic [WIDTH-1:0] addend;
   logic [WIDTH:0]   sum;

   assign accept = start && (state_q != ST_RUN);
`ifdef MUL_ZERO_BYPASS_EN
   assign zero_op = (A == '0) || (B == '0);
`else
   assign zero_op = 1'b0;
`endif
   assign last   = (cnt_q == '0);
   assign addend = q_q[0] ? m_q : '0;

   add_nbit #(
      .WIDTH(WIDTH)
   ) u_add (
      .a   (acc_q),
      .b   (addend),
      .sum (sum)
   );

   always_ff @(posedge clk) begin
      if (!rst_n) state_q <= ST_IDLE;
      else        state_q <= state_d;
   end

   always_comb begin
      state_d = state_q;
      unique case (state_q)
         ST_IDLE: if (start) state_d = zero_op ? ST_DONE : ST_RUN;
         ST_RUN:  if (last) state_d = ST_DONE;
         ST_DONE: state_d = start ? (zero_op ? ST_DONE : ST_RUN) : ST_IDLE;
         default: state_d = ST_IDLE;
      endcase
   end

   always_comb begin
      busy = (state_q == ST_RUN);
      done = (state_q == ST_DONE);
   end

   assign P = p_q;

   // Carry-out of the adder lands in the ACC MSB after the right shift.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         m_q   <= '0;
         acc_q <= '0;
         q_q   <= '0;
         cnt_q <= '0;
         p_q   <= '0;
      end else if (accept) begin
         m_q   <= A;
         q_q   <= B;
         acc_q <= '0;
         cnt_q <= CW'(WIDTH - 1);
         if (zero_op) p_q <= '0;
      end else if (state_q == ST_RUN) begin
         acc_q <= sum[WIDTH:1];
         q_q   <= {sum[0], q_q[WIDTH-1:1]};
         cnt_q <= cnt_q - CW'(1);
         if (last) p_q <= {sum, q_q[WIDTH-1:1]};
      end
   end

endmodule

// File: tb/tb_shift_add_mul.sv
// Directed self-checking bench for shift_add_mul at WIDTH=8 plus a full sweep at WIDTH=4.
module tb_shift_add_mul;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        start = 1'b0;
   logic [7:0]  a = '0;
   logic [7:0]  b = '0;
   logic        busy, done;
   logic [15:0] p;

   logic        start4 = 1'b0;
   logic [3:0]  a4 = '0;
   logic [3:0]  b4 = '0;
   logic        busy4, done4;
   logic [7:0]  p4;

   int n_checks = 0;
   int n_pass   = 0;
   int lat, nb, cnt;

`ifdef MUL_ZERO_BYPASS_EN
   localparam int ZeroLat = 0;
`else
   localparam int ZeroLat = 8;
`endif

   always #5 clk = ~clk;

   shift_add_mul #(.WIDTH(8)) dut8 (
      .clk   (clk),
      .rst_n (rst_n),
      .start (start),
      .A     (a),
      .B     (b),
      .busy  (busy),
      .done  (done),
      .P     (p)
   );

   shift_add_mul #(.WIDTH(4)) dut4 (
      .clk   (clk),
      .rst_n (rst_n),
      .start (start4),
      .A     (a4),
      .B     (b4),
      .busy  (busy4),
      .done  (done4),
      .P     (p4)
   );

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got === exp) n_pass++;
      else $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
   endtask

   // Leaves the bench at the negedge following the accept edge.
   task automatic launch(input logic [7:0] x, input logic [7:0] y);
      @(negedge clk);
      a = x;
      b = y;
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
   endtask

   task automatic wait_done(output int l, output int n);
      l = 0;
      n = 0;
      while (!done && l < 40) begin
         if (busy) n++;
         @(negedge clk);
         l++;
      end
   endtask

   task automatic run_mul(input string tag, input logic [7:0] x, input logic [7:0] y);
      int l, n;
      launch(x, y);
      wait_done(l, n);
      check({tag, " done"}, 32'(done), 32'd1);
      check({tag, " P"}, 32'(p), 32'(x) * 32'(y));
   endtask

   initial begin
      repeat (2) @(negedge clk);
      check("rst busy", 32'(busy), 0);
      check("rst done", 32'(done), 0);
      check("rst P", 32'(p), 0);
      check("rst busy4", 32'(busy4), 0);
      check("rst P4", 32'(p4), 0);
      rst_n = 1'b1;

      // Basic 13*11 with latency and busy length
      launch(8'd13, 8'd11);
      wait_done(lat, nb);
      check("t1 latency", 32'(lat), 8);
      check("t1 busy cycles", 32'(nb), 8);
      check("t1 P", 32'(p), 143);
      @(negedge clk);
      check("t1 done pulse", 32'(done), 0);
      check("t1 P hold", 32'(p), 143);

      run_mul("t2 255x255", 8'd255, 8'd255);
      run_mul("t2 128x2", 8'd128, 8'd2);

      // start during RUN is ignored
      launch(8'd200, 8'd3);
      repeat (3) @(negedge clk);
      a = 8'd1;
      b = 8'd1;
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      wait_done(lat, nb);
      check("t3 latency", 32'(lat), 4);
      check("t3 P", 32'(p), 600);
      @(negedge clk);
      check("t3 single done", 32'(done), 0);

      // Back-to-back restart from DONE
      launch(8'd13, 8'd11);
      wait_done(lat, nb);
      check("t4 first P", 32'(p), 143);
      a = 8'd7;
      b = 8'd6;
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      check("t4 no idle busy", 32'(busy), 1);
      check("t4 P held", 32'(p), 143);
      wait_done(lat, nb);
      check("t4 period", 32'(lat + 1), 9);
      check("t4 P", 32'(p), 42);

      // Reset mid-RUN
      launch(8'd100, 8'd100);
      repeat (3) @(negedge clk);
      rst_n = 1'b0;
      @(negedge clk);
      rst_n = 1'b1;
      check("t5 busy", 32'(busy), 0);
      check("t5 done", 32'(done), 0);
      check("t5 P", 32'(p), 0);
      cnt = 0;
      repeat (12) begin
         @(negedge clk);
         if (done || busy) cnt++;
      end
      check("t5 no activity", 32'(cnt), 0);
      run_mul("t5 fresh", 8'd100, 8'd100);

      // Zero operand
      launch(8'd0, 8'd200);
      wait_done(lat, nb);
      check("t6 latency", 32'(lat), 32'(ZeroLat));
      check("t6 busy cycles", 32'(nb), 32'(ZeroLat));
      check("t6 P", 32'(p), 0);
      run_mul("t6 200x0", 8'd200, 8'd0);

      // Full sweep at WIDTH=4
      for (int i = 0; i < 16; i++) begin
         for (int j = 0; j < 16; j++) begin
            @(negedge clk);
            a4 = 4'(i);
            b4 = 4'(j);
            start4 = 1'b1;
            @(negedge clk);
            start4 = 1'b0;
            lat = 0;
            while (!done4 && lat < 30) begin
               @(negedge clk);
               lat++;
            end
            check($sformatf("w4 %0dx%0d", i, j), 32'(p4), 32'(i * j));
         end
      end

      // Strided sweep at WIDTH=8
      for (int i = 0; i < 256; i += 17) begin
         for (int j = 0; j < 256; j += 17) begin
            run_mul($sformatf("w8 %0dx%0d", i, j), 8'(i), 8'(j));
         end
      end

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
